// File: rtl/backward_propagation.sv
// rtl/backward_propagation.sv - backward (training) pass of the 2-2-1 XOR network
// Snapshots inputs, computes deltas in Q8.8, then writes gradient-descent updated weights/biases.
`timescale 1ns/1ps
module backward_propagation #(
    parameter int dataWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_bp,
    input  logic [dataWidth-1:0] x1,
    input  logic [dataWidth-1:0] x2,
    input  logic [dataWidth-1:0] h1,
    input  logic [dataWidth-1:0] h2,
    input  logic [dataWidth-1:0] y,
    input  logic [dataWidth-1:0] target,
    input  logic [dataWidth-1:0] lr,
    input  logic [dataWidth-1:0] w11,
    input  logic [dataWidth-1:0] w12,
    input  logic [dataWidth-1:0] w21,
    input  logic [dataWidth-1:0] w22,
    input  logic [dataWidth-1:0] w31,
    input  logic [dataWidth-1:0] w32,
    input  logic [dataWidth-1:0] b1,
    input  logic [dataWidth-1:0] b2,
    input  logic [dataWidth-1:0] b3,
    output logic [dataWidth-1:0] w11_new,
    output logic [dataWidth-1:0] w12_new,
    output logic [dataWidth-1:0] w21_new,
    output logic [dataWidth-1:0] w22_new,
    output logic [dataWidth-1:0] w31_new,
    output logic [dataWidth-1:0] w32_new,
    output logic [dataWidth-1:0] b1_new,
    output logic [dataWidth-1:0] b2_new,
    output logic [dataWidth-1:0] b3_new,
    output logic [dataWidth-1:0] err,
    output logic                 bp_valid
);

    localparam int W    = dataWidth;
    localparam int FRAC = 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_DOUT = 3'd2;
    localparam logic [2:0] S_DHID = 3'd3;
    localparam logic [2:0] S_UPD  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic signed [W-1:0]   MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]   ONE_V = W'(1 << FRAC);
    localparam logic signed [2*W-1:0] MAX_P = {{W{1'b0}}, MAX_V};
    localparam logic signed [2*W-1:0] MIN_P = {{W{1'b1}}, MIN_V};

    function automatic logic signed [W-1:0] sat_p(input logic signed [2*W-1:0] v);
        if (v > MAX_P)
            return MAX_V;
        else if (v < MIN_P)
            return MIN_V;
        else
            return v[W-1:0];
    endfunction

    // Product rescaled by an arithmetic (flooring) shift before clamping.
    function automatic logic signed [W-1:0] mul_s(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        p = p >>> FRAC;
        return sat_p(p);
    endfunction

    function automatic logic signed [W-1:0] sub_s(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        logic signed [W:0] s;
        s = {a[W-1], a} - {b[W-1], b};
        return sat_p({{(W-1){s[W]}}, s});
    endfunction

    function automatic logic signed [W-1:0] dsig(input logic signed [W-1:0] v);
        return mul_s(v, sub_s(ONE_V, v));
    endfunction

    logic [2:0] state_q, state_d;
    logic signed [W-1:0] x1_q, x1_d, x2_q, x2_d, h1_q, h1_d, h2_q, h2_d;
    logic signed [W-1:0] y_q, y_d, tgt_q, tgt_d, lr_q, lr_d;
    logic signed [W-1:0] w11_q, w11_d, w12_q, w12_d, w21_q, w21_d, w22_q, w22_d;
    logic signed [W-1:0] w31_q, w31_d, w32_q, w32_d;
    logic signed [W-1:0] b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
    logic signed [W-1:0] delta1_q, delta1_d, delta2_q, delta2_d, delta3_q, delta3_d;
    logic signed [W-1:0] w11n_q, w11n_d, w12n_q, w12n_d, w21n_q, w21n_d, w22n_q, w22n_d;
    logic signed [W-1:0] w31n_q, w31n_d, w32n_q, w32n_d;
    logic signed [W-1:0] b1n_q, b1n_d, b2n_q, b2n_d, b3n_q, b3n_d;
    logic signed [W-1:0] err_q, err_d;
    logic                valid_q, valid_d;

    logic signed [W-1:0] e_c, g1_c, g2_c, g3_c;

    assign e_c  = sub_s(y_q, tgt_q);
    assign g1_c = mul_s(lr_q, delta1_q);
    assign g2_c = mul_s(lr_q, delta2_q);
    assign g3_c = mul_s(lr_q, delta3_q);

    always_comb begin
        state_d  = state_q;
        x1_d     = x1_q;     x2_d     = x2_q;
        h1_d     = h1_q;     h2_d     = h2_q;
        y_d      = y_q;      tgt_d    = tgt_q;    lr_d = lr_q;
        w11_d    = w11_q;    w12_d    = w12_q;
        w21_d    = w21_q;    w22_d    = w22_q;
        w31_d    = w31_q;    w32_d    = w32_q;
        b1_d     = b1_q;     b2_d     = b2_q;     b3_d = b3_q;
        delta1_d = delta1_q; delta2_d = delta2_q; delta3_d = delta3_q;
        w11n_d   = w11n_q;   w12n_d   = w12n_q;
        w21n_d   = w21n_q;   w22n_d   = w22n_q;
        w31n_d   = w31n_q;   w32n_d   = w32n_q;
        b1n_d    = b1n_q;    b2n_d    = b2n_q;    b3n_d = b3n_q;
        err_d    = err_q;
        valid_d  = valid_q;

        case (state_q)
            S_IDLE: begin
                if (enable_bp) begin
                    state_d = S_LOAD;
                    x1_d  = x1;     x2_d  = x2;
                    h1_d  = h1;     h2_d  = h2;
                    y_d   = y;      tgt_d = target; lr_d = lr;
                    w11_d = w11;    w12_d = w12;
                    w21_d = w21;    w22_d = w22;
                    w31_d = w31;    w32_d = w32;
                    b1_d  = b1;     b2_d  = b2;     b3_d = b3;
                end
            end
            S_LOAD: begin
                state_d  = S_DOUT;
                err_d    = e_c;
                delta3_d = mul_s(e_c, dsig(y_q));
            end
            S_DOUT: begin
                // Hidden deltas use the pre-update output weights.
                state_d  = S_DHID;
                delta1_d = mul_s(mul_s(delta3_q, w31_q), dsig(h1_q));
                delta2_d = mul_s(mul_s(delta3_q, w32_q), dsig(h2_q));
            end
            S_DHID: begin
                state_d = S_UPD;
                w31n_d  = sub_s(w31_q, mul_s(g3_c, h1_q));
                w32n_d  = sub_s(w32_q, mul_s(g3_c, h2_q));
                b3n_d   = sub_s(b3_q, g3_c);
                w11n_d  = sub_s(w11_q, mul_s(g1_c, x1_q));
                w12n_d  = sub_s(w12_q, mul_s(g1_c, x2_q));
                b1n_d   = sub_s(b1_q, g1_c);
                w21n_d  = sub_s(w21_q, mul_s(g2_c, x1_q));
                w22n_d  = sub_s(w22_q, mul_s(g2_c, x2_q));
                b2n_d   = sub_s(b2_q, g2_c);
            end
            S_UPD: begin
                state_d = S_DONE;
                valid_d = 1'b1;
            end
            S_DONE: begin
                // A level-held enable must drop before another pass may start.
                if (!enable_bp) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x1_q     <= '0; x2_q     <= '0;
            h1_q     <= '0; h2_q     <= '0;
            y_q      <= '0; tgt_q    <= '0; lr_q <= '0;
            w11_q    <= '0; w12_q    <= '0;
            w21_q    <= '0; w22_q    <= '0;
            w31_q    <= '0; w32_q    <= '0;
            b1_q     <= '0; b2_q     <= '0; b3_q <= '0;
            delta1_q <= '0; delta2_q <= '0; delta3_q <= '0;
            w11n_q   <= '0; w12n_q   <= '0;
            w21n_q   <= '0; w22n_q   <= '0;
            w31n_q   <= '0; w32n_q   <= '0;
            b1n_q    <= '0; b2n_q    <= '0; b3n_q <= '0;
            err_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x1_q     <= x1_d;     x2_q     <= x2_d;
            h1_q     <= h1_d;     h2_q     <= h2_d;
            y_q      <= y_d;      tgt_q    <= tgt_d;    lr_q <= lr_d;
            w11_q    <= w11_d;    w12_q    <= w12_d;
            w21_q    <= w21_d;    w22_q    <= w22_d;
            w31_q    <= w31_d;    w32_q    <= w32_d;
            b1_q     <= b1_d;     b2_q     <= b2_d;     b3_q <= b3_d;
            delta1_q <= delta1_d; delta2_q <= delta2_d; delta3_q <= delta3_d;
            w11n_q   <= w11n_d;   w12n_q   <= w12n_d;
            w21n_q   <= w21n_d;   w22n_q   <= w22n_d;
            w31n_q   <= w31n_d;   w32n_q   <= w32n_d;
            b1n_q    <= b1n_d;    b2n_q    <= b2n_d;    b3n_q <= b3n_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign w11_new  = w11n_q;
    assign w12_new  = w12n_q;
    assign w21_new  = w21n_q;
    assign w22_new  = w22n_q;
    assign w31_new  = w31n_q;
    assign w32_new  = w32n_q;
    assign b1_new   = b1n_q;
    assign b2_new   = b2n_q;
    assign b3_new   = b3n_q;
    assign err      = err_q;
    assign bp_valid = valid_q;

endmodule

// File: tb/tb_backward_propagation.sv
// tb/tb_backward_propagation.sv - randomized bench for backward_propagation against an integer model
`timescale 1ns/1ps
module tb_backward_propagation;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable_bp;
    logic [15:0] x1, x2, h1, h2, y, target, lr;
    logic [15:0] w11, w12, w21, w22, w31, w32, b1, b2, b3;
    logic [15:0] w11_new, w12_new, w21_new, w22_new, w31_new, w32_new;
    logic [15:0] b1_new, b2_new, b3_new, err;
    logic        bp_valid;

    backward_propagation #(.dataWidth(16)) dut (
        .clk(clk), .rst(rst), .enable_bp(enable_bp),
        .x1(x1), .x2(x2), .h1(h1), .h2(h2), .y(y), .target(target), .lr(lr),
        .w11(w11), .w12(w12), .w21(w21), .w22(w22), .w31(w31), .w32(w32),
        .b1(b1), .b2(b2), .b3(b3),
        .w11_new(w11_new), .w12_new(w12_new), .w21_new(w21_new), .w22_new(w22_new),
        .w31_new(w31_new), .w32_new(w32_new),
        .b1_new(b1_new), .b2_new(b2_new), .b3_new(b3_new),
        .err(err), .bp_valid(bp_valid)
    );

    // Field i of the 160-bit vectors: w11 w12 w21 w22 w31 w32 b1 b2 b3 err
    logic [159:0] dut_vec, in_vec;
    assign dut_vec = {err, b3_new, b2_new, b1_new, w32_new, w31_new, w22_new, w21_new, w12_new, w11_new};
    assign in_vec  = {16'h0000, b3, b2, b1, w32, w31, w22, w21, w12, w11};
    string nm [10] = '{"w11_new", "w12_new", "w21_new", "w22_new", "w31_new",
                       "w32_new", "b1_new", "b2_new", "b3_new", "err"};

    function automatic int sv(input logic [15:0] v);
        return int'($signed(v));
    endfunction
    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction
    function automatic int mulm(input int a, input int b);
        int p, q;
        p = a * b;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return sat(q);
    endfunction
    function automatic int subm(input int a, input int b);
        return sat(a - b);
    endfunction
    function automatic int dsg(input int v);
        return mulm(v, subm(256, v));
    endfunction

    function automatic logic [159:0] model_pass();
        int e, d1, d2, d3, g1, g2, g3;
        logic [159:0] r;
        e  = subm(sv(y), sv(target));
        d3 = mulm(e, dsg(sv(y)));
        d1 = mulm(mulm(d3, sv(w31)), dsg(sv(h1)));
        d2 = mulm(mulm(d3, sv(w32)), dsg(sv(h2)));
        g1 = mulm(sv(lr), d1);
        g2 = mulm(sv(lr), d2);
        g3 = mulm(sv(lr), d3);
        r[0*16 +: 16] = 16'(subm(sv(w11), mulm(g1, sv(x1))));
        r[1*16 +: 16] = 16'(subm(sv(w12), mulm(g1, sv(x2))));
        r[2*16 +: 16] = 16'(subm(sv(w21), mulm(g2, sv(x1))));
        r[3*16 +: 16] = 16'(subm(sv(w22), mulm(g2, sv(x2))));
        r[4*16 +: 16] = 16'(subm(sv(w31), mulm(g3, sv(h1))));
        r[5*16 +: 16] = 16'(subm(sv(w32), mulm(g3, sv(h2))));
        r[6*16 +: 16] = 16'(subm(sv(b1), g1));
        r[7*16 +: 16] = 16'(subm(sv(b2), g2));
        r[8*16 +: 16] = 16'(subm(sv(b3), g3));
        r[9*16 +: 16] = 16'(e);
        return r;
    endfunction

    // Transaction-level model: a pass started at edge N publishes its results at edge N+4.
    int           cyc = 0;
    int           m_start = 0;
    bit           m_active = 1'b0, m_valid = 1'b0;
    logic [159:0] m_res = '0, m_pend = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_active <= 1'b0;
            m_valid  <= 1'b0;
            m_res    <= '0;
        end else if (!m_active && !m_valid && enable_bp) begin
            m_active <= 1'b1;
            m_start  <= cyc;
            m_pend   <= model_pass();
        end else if (m_active && cyc == m_start + 4) begin
            m_active <= 1'b0;
            m_valid  <= 1'b1;
            m_res    <= m_pend;
        end else if (m_valid && !enable_bp) begin
            m_valid <= 1'b0;
        end
    end

    int n_checks = 0, n_fail = 0;
    int scen = 0, en_cyc = 0, tmo = 0, tmo_seen = 0;
    bit chk_en = 1'b0, prev_mv = 1'b0, prev_dv = 1'b0;

    task automatic lit(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (tmo != tmo_seen) begin
            tmo_seen = tmo;
            n_checks++;
            n_fail++;
            $display("FAIL bp_valid_timeout: bp_valid never rose, expected within 20 cycles");
        end
        if (chk_en) begin
            n_checks++;
            if (bp_valid !== m_valid) begin
                n_fail++;
                $display("FAIL bp_valid @%0d: dut=%b model=%b", cyc, bp_valid, m_valid);
            end
            if (!m_active) begin
                for (int i = 0; i < 10; i++) begin
                    n_checks++;
                    if (dut_vec[i*16 +: 16] !== m_res[i*16 +: 16]) begin
                        n_fail++;
                        $display("FAIL %s @%0d: dut=%h model=%h", nm[i], cyc,
                                 dut_vec[i*16 +: 16], m_res[i*16 +: 16]);
                    end
                end
            end
            if (bp_valid && !prev_dv && (scen == 1 || scen == 4))
                lit("latency", cyc - en_cyc - 1, 4);
            if (m_valid && !prev_mv) begin
                case (scen)
                    1: begin
                        lit("basic err",     int'(m_res[9*16 +: 16]), 'hFF80);
                        lit("basic w31_new", int'(m_res[4*16 +: 16]), 'h0110);
                        lit("basic w32_new", int'(m_res[5*16 +: 16]), 'h0110);
                        lit("basic b3_new",  int'(m_res[8*16 +: 16]), 'h0020);
                        lit("hid w11_new",   int'(m_res[0*16 +: 16]), 'h0108);
                        lit("hid w12_new",   int'(m_res[1*16 +: 16]), 'h0100);
                        lit("hid w21_new",   int'(m_res[2*16 +: 16]), 'h0108);
                        lit("hid w22_new",   int'(m_res[3*16 +: 16]), 'h0100);
                        lit("hid b1_new",    int'(m_res[6*16 +: 16]), 'h0008);
                        lit("hid b2_new",    int'(m_res[7*16 +: 16]), 'h0008);
                    end
                    3: begin
                        for (int i = 0; i < 10; i++)
                            lit({"zero_err ", nm[i]}, int'(m_res[i*16 +: 16]), int'(in_vec[i*16 +: 16]));
                    end
                    4: begin
                        lit("sat b3_new", int'(m_res[8*16 +: 16]), 'h7FFF);
                        lit("sat err",    int'(m_res[9*16 +: 16]), 'hFF80);
                    end
                    default: ;
                endcase
            end
        end
        prev_mv = m_valid;
        prev_dv = bp_valid;
    end

    function automatic logic [15:0] rnd_w();
        if ($urandom_range(0, 7) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 1024)) - 16'd512;
    endfunction

    task automatic rand_inputs();
        x1 = 16'($urandom_range(0, 256)); x2 = 16'($urandom_range(0, 256));
        h1 = 16'($urandom_range(0, 256)); h2 = 16'($urandom_range(0, 256));
        y  = 16'($urandom_range(0, 256)); target = 16'($urandom_range(0, 256));
        if ($urandom_range(0, 9) == 0) begin
            y = 16'($urandom); target = 16'($urandom);
        end
        lr  = 16'($urandom_range(0, 512));
        w11 = rnd_w(); w12 = rnd_w(); w21 = rnd_w(); w22 = rnd_w();
        w31 = rnd_w(); w32 = rnd_w();
        b1  = rnd_w(); b2  = rnd_w(); b3  = rnd_w();
    endtask

    task automatic set_basic();
        x1 = 16'h0100; x2 = 16'h0000; h1 = 16'h0080; h2 = 16'h0080;
        y  = 16'h0080; target = 16'h0100; lr = 16'h0100;
        w11 = 16'h0100; w12 = 16'h0100; w21 = 16'h0100; w22 = 16'h0100;
        w31 = 16'h0100; w32 = 16'h0100;
        b1 = 16'h0000; b2 = 16'h0000; b3 = 16'h0000;
    endtask

    task automatic start_pass();
        @(negedge clk);
        #1 enable_bp = 1'b1;
        en_cyc = cyc;
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bp_valid) seen = 1'b1;
        end
        if (!seen) tmo++;
    endtask

    task automatic finish_pass(input int hold);
        repeat (hold) @(negedge clk);
        #1 enable_bp = 1'b0;
        scen = 0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        enable_bp = 1'b0;
        set_basic();
        @(posedge clk);
        @(negedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        scen = 1; start_pass(); wait_valid(); finish_pass(10);
        start_pass(); wait_valid(); finish_pass(0);

        set_basic();
        w11 = rnd_w(); w12 = rnd_w(); w21 = rnd_w(); w22 = rnd_w();
        w31 = rnd_w(); w32 = rnd_w(); b1 = rnd_w(); b2 = rnd_w(); b3 = rnd_w();
        y = 16'h0080; target = 16'h0080;
        scen = 3; start_pass(); wait_valid(); finish_pass(2);

        set_basic(); b3 = 16'h7FF0;
        scen = 4; start_pass(); wait_valid(); finish_pass(1);

        set_basic(); lr = 16'h0180;
        start_pass();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1; enable_bp = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        start_pass(); wait_valid(); finish_pass(0);

        for (int n = 0; n < 150; n++) begin
            int mode;
            rand_inputs();
            mode = int'($urandom_range(0, 5));
            start_pass();
            if (mode == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #1 enable_bp = 1'b0;
                rand_inputs();
                repeat (6) @(negedge clk);
            end else if (mode == 1) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0; enable_bp = 1'b0;
                @(negedge clk);
            end else begin
                @(negedge clk);
                #1 rand_inputs();
                wait_valid();
                finish_pass(int'($urandom_range(0, 3)));
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
